// File: rtl/two_of_five_tx_pkg.sv
// Shared types and constants for the 2-out-of-5 serial transmitter.
package two_of_five_tx_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int CODE_W       = 5;
    localparam int NDIG_DEFAULT = 4;

    function automatic logic is_bcd(input logic [3:0] d);
        return d <= 4'd9;
    endfunction

endpackage

// File: rtl/two_of_five_tx_bcd_to_2of5.sv
// Combinational BCD digit to 2-out-of-5 code, MSB first; non-BCD inputs map to all zeros.
module bcd_to_2of5
    import two_of_five_tx_pkg::*;
(
    input  logic [3:0]        bcd,
    output logic [CODE_W-1:0] code
);

    always_comb begin
        code = '0;
        case (bcd)
            4'd0:    code = 5'b11000;
            4'd1:    code = 5'b00011;
            4'd2:    code = 5'b00101;
            4'd3:    code = 5'b00110;
            4'd4:    code = 5'b01001;
            4'd5:    code = 5'b01010;
            4'd6:    code = 5'b01100;
            4'd7:    code = 5'b10001;
            4'd8:    code = 5'b10010;
            4'd9:    code = 5'b10100;
            default: code = '0;
        endcase
    end

endmodule

// File: rtl/two_of_five_tx.sv
// Serialises a packed BCD word as 2-out-of-5 codes, first nibble and code MSB first.
// state | meaning
// IDLE  | ready for a word; ser_out held low
// SHIFT | one code bit per cycle until the last digit's last bit
module two_of_five_tx
    import two_of_five_tx_pkg::*;
#(
    parameter int NDIG = NDIG_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [4*NDIG-1:0] digits,
    output logic              in_ready,
    output logic              ser_out,
    output logic              ser_valid,
    output logic              frame_start,
    output logic              err
);

    localparam int          DW       = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [2:0]  LAST_BIT = 3'(CODE_W - 1);
    localparam logic [DW-1:0] LAST_DIG = DW'(NDIG - 1);

    state_t              state, state_nxt;
    logic [2:0]          bit_cnt;
    logic [DW-1:0]       dig_cnt;
    logic [4*NDIG-1:0]   word_q;
    logic [CODE_W-1:0]   code;
    logic                word_ok;
    logic                last_bit;

    always_comb begin
        word_ok = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            if (!is_bcd(digits[4*i +: 4])) word_ok = 1'b0;
        end
    end

    // The captured word shifts left per digit, so the active digit is always the top nibble.
    bcd_to_2of5 u_enc (
        .bcd  (word_q[4*NDIG-1 -: 4]),
        .code (code)
    );

    assign last_bit = (bit_cnt == LAST_BIT) && (dig_cnt == LAST_DIG);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid && word_ok) state_nxt = SHIFT;
            SHIFT:   if (last_bit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready    = 1'b0;
        ser_valid   = 1'b0;
        ser_out     = 1'b0;
        frame_start = 1'b0;
        case (state)
            IDLE: in_ready = 1'b1;
            SHIFT: begin
                ser_valid   = 1'b1;
                ser_out     = code[LAST_BIT - bit_cnt];
                frame_start = (bit_cnt == 3'd0) && (dig_cnt == '0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt <= '0;
            dig_cnt <= '0;
            word_q  <= '0;
            err     <= 1'b0;
        end else begin
            err <= (state == IDLE) && in_valid && !word_ok;
            if (state == IDLE) begin
                bit_cnt <= '0;
                dig_cnt <= '0;
                if (in_valid && word_ok) word_q <= digits;
            end else if (bit_cnt == LAST_BIT) begin
                bit_cnt <= '0;
                dig_cnt <= dig_cnt + 1'b1;
                word_q  <= word_q << 4;
            end else begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_two_of_five_tx.sv
// Directed bench for two_of_five_tx: stream contents, latency, err, reset behaviour.
module tb_two_of_five_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] digits;
    logic        in_ready;
    logic        ser_out;
    logic        ser_valid;
    logic        frame_start;
    logic        err;

    int n_assert = 0;
    int n_fail   = 0;

    logic [4:0] enc_tab [10] = '{5'b11000, 5'b00011, 5'b00101, 5'b00110, 5'b01001,
                                 5'b01010, 5'b01100, 5'b10001, 5'b10010, 5'b10100};

    two_of_five_tx #(.NDIG(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .digits      (digits),
        .in_ready    (in_ready),
        .ser_out     (ser_out),
        .ser_valid   (ser_valid),
        .frame_start (frame_start),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entered just after a negedge (cycle N); leaves at the negedge of cycle N+21.
    task automatic run_word(input string tag, input logic [15:0] w, input logic [19:0] exp,
                            input bit hold, input logic [15:0] w2, output logic [19:0] got);
        in_valid = 1'b1;
        digits   = w;
        chk({tag, " ready@N"}, in_ready, 1'b1);
        @(negedge clk);
        if (hold) digits = w2;
        else      in_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            got[19-i] = ser_out;
            chk({tag, " bit"}, ser_out, exp[19-i]);
            chk({tag, " valid"}, ser_valid, 1'b1);
            chk({tag, " fstart"}, frame_start, (i == 0));
            chk({tag, " busy"}, in_ready, 1'b0);
            chk({tag, " err"}, err, 1'b0);
            @(negedge clk);
        end
        chk({tag, " ready@N+21"}, in_ready, 1'b1);
        chk({tag, " idle valid"}, ser_valid, 1'b0);
        chk({tag, " idle out"}, ser_out, 1'b0);
    endtask

    initial begin
        logic [19:0] got;
        logic [19:0] exp;
        logic [15:0] w;
        int d;

        rst = 1'b1; in_valid = 1'b0; digits = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst ready", in_ready, 1'b1);
        chk("rst valid", ser_valid, 1'b0);
        chk("rst out", ser_out, 1'b0);
        chk("rst fstart", frame_start, 1'b0);
        chk("rst err", err, 1'b0);
        @(negedge clk);

        run_word("w1234", 16'h1234, 20'b00011_00101_00110_01001, 1'b0, 16'h0, got);
        run_word("w0009", 16'h0009, 20'b11000_11000_11000_10100, 1'b0, 16'h0, got);

        in_valid = 1'b1; digits = 16'h12A4;
        @(negedge clk);
        in_valid = 1'b0; digits = '0;
        chk("bad err N+1", err, 1'b1);
        chk("bad valid", ser_valid, 1'b0);
        chk("bad ready", in_ready, 1'b1);
        @(negedge clk);
        chk("bad err N+2", err, 1'b0);
        chk("bad valid N+2", ser_valid, 1'b0);
        chk("bad ready N+2", in_ready, 1'b1);

        run_word("w5678", 16'h5678, 20'b01010_01100_10001_10010, 1'b1, 16'h9999, got);
        run_word("w9999", 16'h9999, 20'b10100_10100_10100_10100, 1'b0, 16'h0, got);

        // Reset during the 7th bit of 1234.
        in_valid = 1'b1; digits = 16'h1234;
        @(negedge clk);
        in_valid = 1'b0;
        exp = 20'b00011_00101_00110_01001;
        for (int i = 0; i < 7; i++) begin
            chk("rstmid bit", ser_out, exp[19-i]);
            chk("rstmid valid", ser_valid, 1'b1);
            if (i < 6) @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("rstmid quiet valid", ser_valid, 1'b0);
            chk("rstmid quiet out", ser_out, 1'b0);
            chk("rstmid quiet err", err, 1'b0);
            chk("rstmid ready", in_ready, 1'b1);
            @(negedge clk);
        end
        run_word("after rst", 16'h1234, 20'b00011_00101_00110_01001, 1'b0, 16'h0, got);

        // A word offered while rst is high must be dropped.
        rst = 1'b1; in_valid = 1'b1; digits = 16'h5678;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        chk("rst prio valid", ser_valid, 1'b0);
        chk("rst prio ready", in_ready, 1'b1);
        @(negedge clk);
        chk("rst prio valid2", ser_valid, 1'b0);

        // Every digit in every position via rotating sequences.
        for (int s = 0; s < 10; s++) begin
            w = '0;
            exp = '0;
            for (int p = 0; p < 4; p++) begin
                d = (s + p) % 10;
                w[15-4*p -: 4] = 4'(d);
                exp[19-5*p -: 5] = enc_tab[d];
            end
            run_word("exh", w, exp, 1'b0, 16'h0, got);
            for (int p = 0; p < 4; p++) begin
                chk("exh two ones", $countones(got[19-5*p -: 5]), 2);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/two_of_five_tx.md
TWO_OF_FIVE_TX -- requirements
Module: two_of_five_tx

Interface
REQ-001 Parameter NDIG, default 4, meaning number of BCD digits per word.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  a BCD word is offered on digits.
REQ-005 digits  input  4*NDIG  packed BCD word; the most significant nibble is the first digit sent.
REQ-006 in_ready  output  1  the block can accept a word this cycle.
REQ-007 ser_out  output  1  serial 2-out-of-5 data bit.
REQ-008 ser_valid  output  1  ser_out carries a valid bit this cycle.
REQ-009 frame_start  output  1  marks the first bit of a word.
REQ-010 err  output  1  one-cycle pulse when an offered word contains a non-BCD digit.

Function
REQ-011 Encoding table per digit, code bits MSB first:
- 0=11000, 1=00011, 2=00101, 3=00110, 4=01001
- 5=01010, 6=01100, 7=10001, 8=10010, 9=10100
REQ-012 FSM states:
- IDLE: in_ready=1 and ser_valid=0.
- SHIFT: in_ready=0 and ser_valid=1.
REQ-013 Acceptance occurs on a cycle N where the state is IDLE, in_valid=1 and every nibble is 0..9; the word is captured and the state goes to SHIFT.
REQ-014 Invalid word: if any nibble on the acceptance cycle is 10..15, the word is dropped, err=1 at cycle N+1 for exactly one cycle, and the state stays IDLE.
REQ-015 Latency: the first bit appears at cycle N+1 with ser_valid=1 and frame_start=1; frame_start=0 on all other cycles.
REQ-016 Bit order:
- one bit per cycle, NDIG*5 consecutive cycles, no gaps;
- digits are sent MSB nibble first, each code MSB first;
- the last bit appears at N+5*NDIG.
REQ-017 The state returns to IDLE after the last bit; in_ready=1 at N+5*NDIG+1; no back-to-back overlap.
REQ-018 Counters:
- bit_cnt runs 0..4; it wraps to 0 and increments dig_cnt.
- dig_cnt runs 0..NDIG-1; at dig_cnt=NDIG-1 with bit_cnt=4 the state exits to IDLE.
REQ-019 in_valid and digits are ignored while in SHIFT; the captured word is not affected by input changes.
REQ-020 When the state is IDLE, ser_out=0.
REQ-021 Every transmitted 5-bit group contains exactly two ones.

Reset
REQ-022 On rst=1 at a clock edge:
- the state goes to IDLE and both counters clear;
- ser_out=0, ser_valid=0, frame_start=0, err=0;
- in_ready=1 from the following cycle.
REQ-023 Reset mid-SHIFT discards the word in flight; no further bits are emitted and no err is raised.
REQ-024 rst has priority over simultaneous in_valid; a word offered in the reset cycle is not accepted.

Structure
REQ-025 The shared package holds:
- the FSM state typedef (IDLE, SHIFT);
- the 5-bit code width constant;
- the default NDIG constant.
REQ-026 The digit encoder is a combinational sub-module, bcd_to_2of5 (4-bit input, 5-bit output, table per REQ-011, output 00000 for 10..15), instantiated once on the currently selected digit.
REQ-027 The block has no other sub-modules; the shift/mux logic, counters and FSM are local.

Verification
REQ-028 Word 16'h1234 accepted at N: bits N+1..N+20 = 00011 00101 00110 01001; frame_start only at N+1; in_ready=1 at N+21.
REQ-029 Word 16'h0009: stream = 11000 11000 11000 10100; err stays 0.
REQ-030 Word 16'h12A4 offered in IDLE: err=1 for one cycle at N+1; ser_valid stays 0; in_ready stays 1.
REQ-031 Word 16'h5678 accepted, then 16'h9999 with in_valid=1 held during SHIFT: stream = 01010 01100 10001 10010; the second word is accepted only at N+21; its stream follows with a new frame_start.
REQ-032 rst pulsed during bit 7 of 16'h1234: ser_valid=0 next cycle; no further bits are emitted; in_ready=1 afterwards; a subsequent word transmits correctly.
REQ-033 Exhaustive check of each digit 0..9 in every position: each 5-bit group has exactly two ones and matches REQ-011.
